// File: rtl/mips_md_pkg.sv
// Shared definitions for the MIPS multiply/divide controller: op encodings,
// FSM state type, default iteration count and a conditional-negate helper.
package mips_md_pkg;

    localparam int unsigned ITER_DEFAULT = 32;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [31:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } md_state_t;

    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Shift-add multiply / restoring divide datapath with operand magnitude
// capture and final sign correction of the HI/LO results.
module md_iter_core
    import mips_md_pkg::*;
(
    input  logic        clk,
    input  logic        load,
    input  logic        step,
    input  logic        is_div,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        mul_zero,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo
);

    logic [63:0] acc_reg;
    logic [63:0] mcand_reg;
    logic [31:0] mplier_reg;
    logic        div_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        div_zero_reg;

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic        sub_ok;
    logic [63:0] prod;
    logic [31:0] quot;
    logic [31:0] rem;

    assign a_neg = is_signed & a[31];
    assign b_neg = is_signed & b[31];
    assign a_mag = cond_neg32(a, a_neg);
    assign b_mag = cond_neg32(b, b_neg);

    // The shifted partial remainder needs 33 bits; the divisor lives in mcand_reg[31:0].
    assign sub_ok = acc_reg[63:31] >= {1'b0, mcand_reg[31:0]};

    always_ff @(posedge clk) begin
        if (load) begin
            acc_reg      <= is_div ? {32'd0, a_mag} : 64'd0;
            mcand_reg    <= {32'd0, is_div ? b_mag : a_mag};
            mplier_reg   <= b_mag;
            div_reg      <= is_div;
            neg_q_reg    <= a_neg ^ b_neg;
            neg_r_reg    <= a_neg;
            div_zero_reg <= (b == 32'd0);
        end else if (step) begin
            if (div_reg) begin
                if (sub_ok)
                    acc_reg <= {acc_reg[62:31] - mcand_reg[31:0], acc_reg[30:0], 1'b1};
                else
                    acc_reg <= {acc_reg[62:0], 1'b0};
            end else begin
                if (mplier_reg[0])
                    acc_reg <= acc_reg + mcand_reg;
                mcand_reg  <= {mcand_reg[62:0], 1'b0};
                mplier_reg <= {1'b0, mplier_reg[31:1]};
            end
        end
    end

    // Multiplier becomes zero once the current iteration's shift is applied.
    assign mul_zero = ~div_reg & (mplier_reg[31:1] == 31'd0);

    assign prod = neg_q_reg ? (~acc_reg + 64'd1) : acc_reg;
    assign quot = div_zero_reg ? DIV_ZERO_QUOT : cond_neg32(acc_reg[31:0], neg_q_reg);
    assign rem  = cond_neg32(acc_reg[63:32], neg_r_reg);

    assign res_hi = div_reg ? rem  : prod[63:32];
    assign res_lo = div_reg ? quot : prod[31:0];

endmodule

// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS multiply/divide controller owning HI/LO and the pipeline stall.
// Optional feature macro: MD_EARLY_OUT_EN (multiply exits once multiplier is exhausted).
module mips_muldiv_ctrl
    import mips_md_pkg::*;
#(
    parameter int unsigned ITER = ITER_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        mf_req,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    md_state_t        state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic [31:0]      hi_reg;
    logic [31:0]      lo_reg;

    logic        is_arith;
    logic        op_div;
    logic        op_signed;
    logic        accept;
    logic        last_iter;
    logic        core_mul_zero;
    logic [31:0] core_hi;
    logic [31:0] core_lo;

    assign is_arith  = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                       (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign op_div    = (md_op == OP_DIV)  || (md_op == OP_DIVU);
    assign op_signed = (md_op == OP_MULT) || (md_op == OP_DIV);
    assign accept    = (state_reg == ST_IDLE) && md_start && is_arith;
    assign last_iter = (cnt_reg == CNT_W'(ITER - 1)) || (EARLY_OUT && core_mul_zero);

    md_iter_core u_core (
        .clk       (clk),
        .load      (accept),
        .step      (state_reg == ST_CALC),
        .is_div    (op_div),
        .is_signed (op_signed),
        .a         (rs_val),
        .b         (rt_val),
        .mul_zero  (core_mul_zero),
        .res_hi    (core_hi),
        .res_lo    (core_lo)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            hi_reg    <= 32'd0;
            lo_reg    <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg <= ST_CALC;
                        cnt_reg   <= '0;
                        busy_reg  <= 1'b1;
                    end else if (md_start && md_op == OP_MTHI) begin
                        hi_reg <= rs_val;
                    end else if (md_start && md_op == OP_MTLO) begin
                        lo_reg <= rs_val;
                    end
                end
                ST_CALC: begin
                    cnt_reg <= cnt_reg + 1'b1;
                    if (last_iter)
                        state_reg <= ST_FIX;
                end
                ST_FIX: begin
                    hi_reg    <= core_hi;
                    lo_reg    <= core_lo;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Held starts and MF reads wait out the whole computation, FIX included.
    assign stall = (mf_req | md_start) & (state_reg != ST_IDLE);
    assign busy  = busy_reg;
    assign done  = done_reg;
    assign hi    = hi_reg;
    assign lo    = lo_reg;

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Directed self-checking bench for mips_muldiv_ctrl: arithmetic vectors,
// stall behaviour, MTLO forwarding and mid-operation reset.
module tb_mips_muldiv_ctrl;

    localparam int ITER = 32;
`ifdef MD_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        md_start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        mf_req;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    mips_muldiv_ctrl #(.ITER(ITER)) dut (
        .clk      (clk),
        .rst      (rst),
        .md_start (md_start),
        .md_op    (md_op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mf_req   (mf_req),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Cycles from the start edge to the FIX edge.
    function automatic int exp_busy(input logic [2:0] op, input logic [31:0] b);
        logic [31:0] m;
        int it;
        if (!EARLY || op >= 3'd2) return ITER + 1;
        m = (op == 3'd0 && b[31]) ? (~b + 32'd1) : b;
        it = 1;
        for (int i = 0; i < 32; i++) if (m[i]) it = i + 1;
        return it + 1;
    endfunction

    // Issue a one-cycle start, then wait (bounded) until busy drops.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int nbusy);
        @(negedge clk);
        md_start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(negedge clk);
        md_start = 1'b0;
        nbusy = 0;
        while (busy === 1'b1 && nbusy < 100) begin
            nbusy++;
            @(negedge clk);
        end
    endtask

    initial begin
        int nb;
        int d0;
        int nstall;

        vecs[0] = '{"mult_neg",   3'd0, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1] = '{"divu_100_7", 3'd3, 32'd100,       32'd7,         32'd2,         32'd14};
        vecs[2] = '{"div_neg",    3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3] = '{"div_by0",    3'd2, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
        vecs[4] = '{"div_ovf",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
        vecs[5] = '{"divu_by0",   3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
        vecs[6] = '{"multu_max",  3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[7] = '{"div_7_m2",   3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

        rst = 1'b1; md_start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; mf_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mf_req = 1'b1;
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("idle_mf_stall", stall, 1'b0);
        mf_req = 1'b0;

        foreach (vecs[i]) begin
            d0 = done_cnt;
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, nb);
            $display("op=%s a=%h b=%h hi=%h lo=%h busy_cycles=%0d",
                     vecs[i].name, vecs[i].a, vecs[i].b, hi, lo, nb);
            check({vecs[i].name, "_busy"}, nb, exp_busy(vecs[i].op, vecs[i].b));
            check({vecs[i].name, "_done"}, done, 1'b1);
            check({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            check({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            @(negedge clk);
            check({vecs[i].name, "_done_off"}, done, 1'b0);
            check({vecs[i].name, "_done_cnt"}, done_cnt - d0, 1);
        end

        // MULTU 6*9 with MF request and a held MTHI start during busy.
        @(negedge clk);
        md_start = 1'b1; md_op = 3'd1; rs_val = 32'd6; rt_val = 32'd9;
        @(negedge clk);
        md_op = 3'd4; rs_val = 32'h0000_ABCD; mf_req = 1'b1;
        nb = 0; nstall = 0;
        while (busy === 1'b1 && nb < 100) begin
            nb++;
            if (stall === 1'b1) nstall++;
            @(negedge clk);
        end
        $display("op=multu_stall a=6 b=9 hi=%h lo=%h stall_cycles=%0d", hi, lo, nstall);
        check("stall_cycles", nstall, exp_busy(3'd1, 32'd9));
        check("stall_done_cycle", stall, 1'b0);
        check("stall_done", done, 1'b1);
        check("stall_lo", lo, 32'd54);
        @(negedge clk);
        md_start = 1'b0; mf_req = 1'b0;
        check("held_mthi_hi", hi, 32'h0000_ABCD);
        check("held_mthi_busy", busy, 1'b0);

        // MTLO in IDLE, MFLO the next cycle.
        @(negedge clk);
        md_start = 1'b1; md_op = 3'd5; rs_val = 32'h0000_1234;
        @(negedge clk);
        md_start = 1'b0; mf_req = 1'b1;
        $display("op=mtlo rs=%h lo=%h stall=%b", rs_val, lo, stall);
        check("mtlo_lo", lo, 32'h0000_1234);
        check("mtlo_stall", stall, 1'b0);
        mf_req = 1'b0;

        // Reset in the middle of a divide.
        d0 = done_cnt;
        @(negedge clk);
        md_start = 1'b1; md_op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        md_start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("op=div_rst hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        check("mid_rst_done", done, 1'b0);
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", done_cnt - d0, 0);

        do_op(3'd1, 32'd2, 32'd3, nb);
        $display("op=multu_after_rst a=2 b=3 hi=%h lo=%h busy_cycles=%0d", hi, lo, nb);
        check("post_rst_busy", nb, exp_busy(3'd1, 32'd3));
        check("post_rst_lo", lo, 32'd6);
        check("post_rst_hi", hi, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_muldiv_ctrl.md
# mips_muldiv_ctrl

Iterative multiply/divide controller for the MIPS pipeline. Owns the HI/LO registers and sequences a shared 32-iteration shift-add / restoring-divide datapath for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It raises a pipeline stall whenever the ID/EX stage asks for HI/LO, or issues a new op, while a computation is in flight. It sits beside the EX stage and is driven by the main control decoder.

## Interface
- `ITER`, default 32: iterations per multiply or divide; equals the operand width.
- `clk`  in  1: pipeline clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high; aborts any operation in progress.
- `md_start`  in  1: issue request, qualified by `md_op`.
- `md_op`  in  3: operation; encodings live in the package.
- `rs_val`  in  32: multiplicand or dividend; also the MTHI/MTLO write data.
- `rt_val`  in  32: multiplier or divisor.
- `mf_req`  in  1: MFHI or MFLO present in the requesting stage.
- `stall`  out  1: combinational; freezes PC, IF/ID and ID/EX.
- `busy`  out  1: registered; high while an operation is in flight.
- `done`  out  1: registered; single-cycle pulse when HI/LO are updated by MUL or DIV.
- `hi`, `lo`  out  32 each: architectural HI and LO.

## Operation
- States: IDLE, CALC, FIX.
- IDLE + `md_start` with MULT/MULTU/DIV/DIVU:
  - latch operand magnitudes (signed ops take absolute values) and the result-sign flags;
  - clear the 64-bit accumulator and the iteration counter;
  - go to CALC.
- IDLE + MTHI or MTLO: write `rs_val` into HI or LO at that edge and stay in IDLE. `done` is not pulsed.
- CALC performs one iteration per cycle; the counter counts 0..ITER-1, then the state goes to FIX.
  - Multiply: if the multiplier LSB is set, add the left-shifting multiplicand into the accumulator; then shift the multiplier right.
  - Divide: restoring divide; shift the remainder/quotient pair left and subtract the divisor. On a non-negative result keep the difference and set the quotient bit.
- FIX:
  - Apply sign correction: a product is negated if the operand signs differ; the quotient is negated if the signs differ; the remainder takes the sign of the dividend.
  - Write HI/LO. For multiply, HI = product[63:32] and LO = product[31:0]. For divide, HI = remainder and LO = quotient.
  - Then go to IDLE.
- Divide by zero (rt_val = 0), signed or unsigned: LO = 0xFFFF_FFFF, HI = `rs_val`. It still takes the full latency.
- Signed overflow, 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- All arithmetic is modulo 2^32 per register.
- `stall` = (`mf_req` | `md_start`) & (state != IDLE).
  - A start issued while the block is busy is held by the pipeline and accepted in the first IDLE cycle.
  - MF reads are never stalled in IDLE.
- The cycle in which `done` is high is IDLE: a start in that cycle is accepted, and the HI/LO values are already valid.
- Reset values: state IDLE, HI = LO = 0, `busy` = 0, `done` = 0, counter 0. The accumulator is don't-care.

## Timing
- Start sampled at edge E0.
- CALC iterations occur at edges E1..E32; FIX writes HI/LO at edge E33.
- `busy` is high for the 33 cycles between E0 and E33.
- `done` is high for the one cycle after E33.
- Total latency is 34 cycles from the start cycle to the first valid MF read.
- A reset asserted in any cycle returns the block to reset values at the next edge. A partial result is never written.
- MTHI/MTLO take effect at the accepting edge; an MF read in the following cycle sees the new value.

## Configuration
- `MD_EARLY_OUT_EN` defined:
  - In CALC, a multiply whose remaining multiplier is zero after an iteration goes directly to FIX.
  - MULTU with rt_val = 1: start E0, one iteration at E1, FIX at E2, `done` in the cycle after E2.
  - Divide latency is unchanged.
- `MD_EARLY_OUT_EN` undefined: every multiply and divide takes the fixed 34-cycle latency.

## Structure
- Package `mips_md_pkg` holds:
  - `md_op` encodings: MULT = 0, MULTU = 1, DIV = 2, DIVU = 3, MTHI = 4, MTLO = 5;
  - the state enum;
  - the `ITER` default;
  - the divide-by-zero constant 0xFFFF_FFFF.
- One sub-module, `md_iter_core`, contains the 64-bit accumulator, the shift/add/subtract step and the sign fix. `mips_muldiv_ctrl` keeps the FSM, the counter, stall logic and HI/LO.

## Test plan
- MULT rs = 0xFFFF_FFFD, rt = 7 -> after 34 cycles HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB; `busy` high 33 cycles; exactly one `done` pulse.
- DIVU 100 / 7 -> LO = 14, HI = 2. DIV 0xFFFF_FFF9 / 2 -> LO = 0xFFFF_FFFD, HI = 0xFFFF_FFFF.
- DIV 5 / 0 -> LO = 0xFFFF_FFFF, HI = 5 after 34 cycles.
- Start MULTU 6 × 9, then `mf_req` = 1 from the next cycle -> `stall` = 1 through the last busy cycle and 0 in the `done` cycle, LO = 54. A second `md_start` held during busy is accepted in the `done` cycle.
- MTLO 0x1234 in IDLE, then MFLO in the next cycle -> LO = 0x1234 with no stall.
- DIV started, `rst` asserted at iteration 10 -> next cycle `busy` = 0, HI = LO = 0, no `done`. A new MULTU 2 × 3 then yields LO = 6.
